tdm_fir_engine: RTL and testbench

Time-multiplexed FIR core that sits directly downstream of the TDM serializer and upstream of the TDM deserializer. It accepts one sample per cycle, each tagged with its channel index. It keeps a separate delay line per channel and uses one shared, run-time-loadable coefficient set. It emits one filtered sample per accepted input, carrying the same channel tag, after a fixed 2-cycle pipeline.

---
 rtl/tdm_fir_pkg.sv | 37 +++
 rtl/tdm_fir_mac_tree.sv | 86 ++++++++
 rtl/tdm_fir_engine.sv | 127 ++++++++++++
 tb/tb_tdm_fir_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_fir_pkg.sv
// Shared widths, accumulator sizing and the round/shift/saturate helper for the TDM FIR core.
package tdm_fir_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_COEF_WIDTH   = 16;
    localparam int DEF_NUM_TAPS     = 8;
    localparam int DEF_OUT_SHIFT    = 14;

    // Wide enough that summing every full-width product can never overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps) + 1;
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_DATA_WIDTH, DEF_COEF_WIDTH, DEF_NUM_TAPS);

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
    typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int               shift,
                                                     input int               dw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_fir_mac_tree.sv
// Product, sum and round/saturate pipeline: result registered two edges after the sample edge.
// No backpressure; flush discards everything in flight and leaves the output data/tag holding.
module tdm_fir_mac_tree
    import tdm_fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int NUM_TAPS   = DEF_NUM_TAPS,
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
    parameter int CH_W       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         vld_i,
    input  logic [CH_W-1:0]              chan_i,
    input  logic signed [DATA_WIDTH-1:0] taps_i  [NUM_TAPS],
    input  logic signed [COEF_WIDTH-1:0] coefs_i [NUM_TAPS],
    output logic                         vld_o,
    output logic signed [DATA_WIDTH-1:0] dat_o,
    output logic [CH_W-1:0]              chan_o
);

    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);

    logic signed [PW-1:0]         prod_d [NUM_TAPS];
    logic signed [PW-1:0]         prod_q [NUM_TAPS];
    logic signed [ACC_W-1:0]      acc_d, acc_q;
    logic signed [DATA_WIDTH-1:0] dat_d, dat_q;
    logic                         v1_q, v2_q, vld_q;
    logic [CH_W-1:0]              c1_q, c2_q, chan_q;

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_d[k] = PW'(taps_i[k]) * PW'(coefs_i[k]);
        end
    end

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc_d = acc_d + ACC_W'(prod_q[k]);
        end
    end

    assign dat_d = DATA_WIDTH'(sat_round(64'(acc_q), OUT_SHIFT, DATA_WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod_q[k] <= '0;
            end
            acc_q  <= '0;
            dat_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            vld_q  <= 1'b0;
            c1_q   <= '0;
            c2_q   <= '0;
            chan_q <= '0;
        end else begin
            v1_q  <= vld_i & ~flush_i;
            v2_q  <= v1_q & ~flush_i;
            vld_q <= v2_q & ~flush_i;
            if (vld_i) begin
                prod_q <= prod_d;
                c1_q   <= chan_i;
            end
            if (v1_q) begin
                acc_q <= acc_d;
                c2_q  <= c1_q;
            end
            // Data and tag only move with a surviving result so they hold while idle.
            if (v2_q && !flush_i) begin
                dat_q  <= dat_d;
                chan_q <= c2_q;
            end
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign chan_o = chan_q;

endmodule

// File: rtl/tdm_fir_engine.sv
// TDM FIR: per-channel delay lines, shared loadable coefficients, one result per accepted sample 2 edges later.
// No backpressure; out-of-range channels and flush cycles drop the sample.
module tdm_fir_engine
    import tdm_fir_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
    parameter int NUM_TAPS     = DEF_NUM_TAPS,
    parameter int OUT_SHIFT    = DEF_OUT_SHIFT,
    parameter int CH_W         = $clog2(NUM_CHANNELS),
    parameter int TAP_W        = $clog2(NUM_TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]              in_chan,
    input  logic                         flush,
    input  logic                         coef_we,
    input  logic [TAP_W-1:0]             coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]              out_chan,
    output logic                         seq_err
);

    localparam logic [CH_W:0]               NCH      = (CH_W + 1)'(NUM_CHANNELS);
    localparam logic [TAP_W:0]              NTP      = (TAP_W + 1)'(NUM_TAPS);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1 << OUT_SHIFT);

    logic signed [DATA_WIDTH-1:0] line_q [NUM_CHANNELS][NUM_TAPS-1];
    logic signed [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] taps   [NUM_TAPS];
    logic [CH_W-1:0]              exp_q, exp_d;
    logic                         seq_err_q, seq_err_d;
    logic                         chan_ok, coef_ok, accept;
    logic [CH_W-1:0]              ch_idx;
    logic [CH_W:0]                chan_inc;

    assign chan_ok  = {1'b0, in_chan} < NCH;
    assign coef_ok  = {1'b0, coef_addr} < NTP;
    assign accept   = in_valid & ~flush & chan_ok;
    assign ch_idx   = chan_ok ? in_chan : '0;
    assign chan_inc = {1'b0, in_chan} + (CH_W + 1)'(1);

    // Tap vector is the incoming sample followed by the channel's pre-shift history.
    always_comb begin
        taps[0] = in_data;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps[k] = line_q[ch_idx][k-1];
        end
    end

    always_comb begin
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        if (flush) begin
            exp_d = '0;
        end else if (in_valid) begin
            if (in_chan != exp_q) begin
                seq_err_d = 1'b1;
            end
            if (chan_ok) begin
                exp_d = (chan_inc == NCH) ? '0 : chan_inc[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                for (int k = 0; k < NUM_TAPS - 1; k++) begin
                    line_q[ch][k] <= '0;
                end
            end
        end else if (accept) begin
            line_q[ch_idx][0] <= in_data;
            for (int k = 1; k < NUM_TAPS - 1; k++) begin
                line_q[ch_idx][k] <= line_q[ch_idx][k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= (k == 0) ? COEF_ONE : '0;
            end
        end else if (coef_we && coef_ok) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    tdm_fir_mac_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .OUT_SHIFT  (OUT_SHIFT),
        .CH_W       (CH_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .vld_i   (accept),
        .chan_i  (in_chan),
        .taps_i  (taps),
        .coefs_i (coef_q),
        .vld_o   (out_valid),
        .dat_o   (out_data),
        .chan_o  (out_chan)
    );

    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_tdm_fir_engine.sv
// Randomized bench for tdm_fir_engine against a per-channel history/coefficient reference model.
module tb_tdm_fir_engine;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int NT  = 8;
    localparam int SH  = 14;
    localparam int CHW = 2;
    localparam int TW  = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic [CHW-1:0]       in_chan;
    logic                 flush;
    logic                 coef_we;
    logic [TW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [CHW-1:0]       out_chan;
    logic                 seq_err;

    always #5 clk = ~clk;

    tdm_fir_engine #(
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW),
        .COEF_WIDTH   (CW),
        .NUM_TAPS     (NT),
        .OUT_SHIFT    (SH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .seq_err   (seq_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: newest-first history per channel, coefficient array,
    // and a 4-slot ring of expected results keyed by edge number.
    longint hist   [NCH][NT];
    longint coef_m [NT];
    int     exp_ch;
    bit     seq_m;
    bit     due_v  [4];
    longint due_d  [4];
    int     due_c  [4];
    longint last_d;
    int     last_c;
    int     n;
    int     rr;

    function automatic longint model_y(input int ch, input longint d);
        longint sum;
        longint r;
        sum = coef_m[0] * d;
        for (int k = 1; k < NT; k++) sum += coef_m[k] * hist[ch][k-1];
        r = (sum + (longint'(1) <<< (SH - 1))) >>> SH;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic longint rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return longint'(t);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NT; k++) hist[c][k] = 0;
        for (int k = 0; k < NT; k++) coef_m[k] = 0;
        coef_m[0] = longint'(1) <<< SH;
        for (int i = 0; i < 4; i++) due_v[i] = 1'b0;
        exp_ch = 0;
        seq_m  = 1'b0;
        last_d = 0;
        last_c = 0;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        in_data   = '0;
        in_chan   = '0;
        flush     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
    endtask

    task automatic step(input bit v, input longint d, input int ch, input bit fl,
                        input bit we, input int ad, input longint cd);
        longint y;
        bit     acc;
        in_valid  = v;
        in_data   = DW'(d);
        in_chan   = CHW'(ch);
        flush     = fl;
        coef_we   = we;
        coef_addr = TW'(ad);
        coef_data = CW'(cd);
        acc = v && !fl && (ch < NCH);
        y = acc ? model_y(ch, d) : 0;
        @(posedge clk);
        n++;
        due_v[(n + 2) % 4] = 1'b0;
        if (fl) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NT; k++) hist[c][k] = 0;
            exp_ch = 0;
            due_v[n % 4]       = 1'b0;
            due_v[(n + 1) % 4] = 1'b0;
        end else if (v) begin
            if (ch != exp_ch) seq_m = 1'b1;
            if (ch < NCH) exp_ch = (ch + 1) % NCH;
        end
        if (acc) begin
            for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = d;
            due_v[(n + 2) % 4] = 1'b1;
            due_d[(n + 2) % 4] = y;
            due_c[(n + 2) % 4] = ch;
        end
        if (we && ad < NT) coef_m[ad] = cd;
        #1;
        chk("out_valid", out_valid, due_v[n % 4]);
        if (due_v[n % 4]) begin
            last_d = due_d[n % 4];
            last_c = due_c[n % 4];
        end
        chk("out_data", longint'(out_data), last_d);
        chk("out_chan", out_chan, last_c);
        chk("seq_err", seq_err, seq_m);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rr_sample(input longint d);
        step(1, d, rr, 0, 0, 0, 0);
        rr = (rr + 1) % NCH;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        n  = 0;
        rr = 0;
        drive_idle();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_seq_err", seq_err, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Identity echo, then random round-robin traffic.
        rr_sample(100);
        rr_sample(200);
        rr_sample(-300);
        rr_sample(400);
        idle(3);
        for (int i = 0; i < 24; i++) rr_sample(rnd16());

        // Four-tap average, impulse on channel 1 only.
        for (int k = 0; k < NT; k++) step(0, 0, 0, 0, 1, k, (k < 4) ? 4096 : 0);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < NCH; c++) rr_sample((r == 0 && c == 1) ? 16384 : 0);
        idle(2);

        // Saturation; coefficient writes land on the same edges as accepted samples.
        step(1, 1000, 0, 0, 1, 0, 32767);
        step(1, 0, 1, 0, 1, 1, 0);
        step(1, 0, 2, 0, 1, 2, 0);
        step(1, 0, 3, 0, 1, 3, 0);
        rr = 0;
        rr_sample(32767);
        rr_sample(rnd16());
        rr_sample(rnd16());
        rr_sample(rnd16());
        rr_sample(-32768);
        rr_sample(rnd16());
        idle(2);

        // Random coefficients and sparse random traffic in channel order.
        for (int i = 0; i < 64; i++) begin
            bit     v;
            bit     we;
            longint cd;
            v  = ($urandom % 5) != 0;
            we = ($urandom % 4) == 0;
            cd = rnd16() >>> ($urandom % 4);
            step(v, rnd16(), rr, 0, we, $urandom % NT, cd);
            if (v) rr = (rr + 1) % NCH;
        end

        // Fill history, flush with a sample present, then probe with an impulse.
        for (int i = 0; i < 12; i++) rr_sample(rnd16() | 1);
        step(1, 1234, rr, 1, 0, 0, 0);
        rr = 0;
        for (int i = 0; i < 8; i++) rr_sample((i == 0) ? 16384 : 0);
        idle(3);

        // Channel-order violation 0,1,3 then correct and random-order traffic.
        rr = 0;
        rr_sample(rnd16());
        rr_sample(rnd16());
        step(1, rnd16(), 3, 0, 0, 0, 0);
        rr = 0;
        for (int i = 0; i < 8; i++) rr_sample(rnd16());
        for (int i = 0; i < 32; i++) step(1, rnd16(), $urandom % NCH, 0, 0, 0, 0);

        // Asynchronous reset mid-stream.
        rr = 0;
        for (int i = 0; i < 3; i++) rr_sample(rnd16());
        chk("pre_rst_valid", out_valid, 1);
        drive_idle();
        #3 reset = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_seq_err", seq_err, 0);
        chk("async_rst_data", longint'(out_data), 0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        rr = 0;
        rr_sample(-12345);
        rr_sample(777);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
